// File: rtl/mac_dot_sequencer_if.sv
// Command, operand-memory, MAC and result signals of mac_dot_sequencer.
// master = sequencer side, slave = surrounding system (memories, MAC, command/result user).
interface mac_dot_sequencer_if #(
    parameter int unsigned A_WIDTH    = 18,
    parameter int unsigned RES_WIDTH  = 48,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned LEN_WIDTH  = 8
);
    logic                  START;
    logic [ADDR_WIDTH-1:0] CMD_BASE;
    logic [LEN_WIDTH-1:0]  CMD_LEN;
    logic                  CMD_SUB;
    logic                  CMD_ACC;
    logic                  BUSY;
    logic [ADDR_WIDTH-1:0] OP_ADDR;
    logic [A_WIDTH-1:0]    OPA_DATA;
    logic [A_WIDTH-1:0]    OPB_DATA;
    logic [A_WIDTH-1:0]    MAC_A;
    logic [A_WIDTH-1:0]    MAC_B;
    logic                  MAC_LOAD;
    logic                  MAC_SUB;
    logic [RES_WIDTH-1:0]  MAC_RES;
    logic                  RES_VALID;
    logic                  RES_READY;
    logic [RES_WIDTH-1:0]  RESULT;
    logic                  SAT;

    modport master (
        input  START, CMD_BASE, CMD_LEN, CMD_SUB, CMD_ACC,
        input  OPA_DATA, OPB_DATA, MAC_RES, RES_READY,
        output BUSY, OP_ADDR, MAC_A, MAC_B, MAC_LOAD, MAC_SUB,
        output RES_VALID, RESULT, SAT
    );

    modport slave (
        output START, CMD_BASE, CMD_LEN, CMD_SUB, CMD_ACC,
        output OPA_DATA, OPB_DATA, MAC_RES, RES_READY,
        input  BUSY, OP_ADDR, MAC_A, MAC_B, MAC_LOAD, MAC_SUB,
        input  RES_VALID, RESULT, SAT
    );
endinterface

// File: rtl/mac_dot_sequencer.sv
// Sequences a 2-stage signed MAC over N operand pairs and returns the accumulator.
// Optional result saturation to SAT_WIDTH bits: define MAC_SEQ_SAT_EN.
module mac_dot_sequencer #(
    parameter int unsigned A_WIDTH    = 18,
    parameter int unsigned RES_WIDTH  = 48,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned LEN_WIDTH  = 8,
    parameter int unsigned SAT_WIDTH  = 32
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    mac_dot_sequencer_if.master  bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  load_q, load_d;
    logic                  sub_q, sub_d;
    logic                  issue_vld_q, issue_vld_d;
    logic                  op_vld_q;
    logic [1:0]            wait_q, wait_d;
    logic [RES_WIDTH-1:0]  result_q, result_d;
    logic                  sat_q, sat_d;
    logic                  last_term;
    logic [RES_WIDTH-1:0]  cap_val;
    logic                  cap_sat;

    if (SAT_WIDTH < 2 || SAT_WIDTH >= RES_WIDTH) begin : g_sat_width_bad
        $error("SAT_WIDTH must lie in [2, RES_WIDTH)");
    end

    // N=0 behaves as a single zero-operand term, so it is always the last one.
    assign last_term = (len_q == '0) || (cnt_q == len_q - LEN_WIDTH'(1));

`ifdef MAC_SEQ_SAT_EN
    logic [RES_WIDTH-SAT_WIDTH:0] res_hi;
    logic [RES_WIDTH-1:0]         sat_max;

    always_comb begin
        res_hi  = bus.MAC_RES[RES_WIDTH-1:SAT_WIDTH-1];
        sat_max = '0;
        sat_max[SAT_WIDTH-2:0] = '1;
        cap_sat = !((&res_hi) || !(|res_hi));
        if (!cap_sat) begin
            cap_val = bus.MAC_RES;
        end else if (bus.MAC_RES[RES_WIDTH-1]) begin
            cap_val = ~sat_max;
        end else begin
            cap_val = sat_max;
        end
    end
`else
    assign cap_val = bus.MAC_RES;
    assign cap_sat = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        load_d      = load_q;
        sub_d       = sub_q;
        issue_vld_d = 1'b0;
        wait_d      = wait_q;
        result_d    = result_q;
        sat_d       = sat_q;
        unique case (state_q)
            S_IDLE: begin
                load_d = 1'b1;
                sub_d  = 1'b0;
                if (bus.START) begin
                    state_d     = S_ISSUE;
                    addr_d      = bus.CMD_BASE;
                    len_d       = bus.CMD_LEN;
                    cnt_d       = '0;
                    load_d      = bus.CMD_ACC;
                    sub_d       = bus.CMD_SUB;
                    issue_vld_d = (bus.CMD_LEN != '0);
                end
            end
            S_ISSUE: begin
                if (last_term) begin
                    state_d = S_WAIT;
                    load_d  = 1'b1;
                    sub_d   = 1'b0;
                    wait_d  = '0;
                end else begin
                    addr_d      = addr_q + ADDR_WIDTH'(1);
                    cnt_d       = cnt_q + LEN_WIDTH'(1);
                    load_d      = 1'b1;
                    issue_vld_d = 1'b1;
                end
            end
            // Three cycles cover memory latency plus the two MAC pipeline stages.
            S_WAIT: begin
                wait_d = wait_q + 2'd1;
                if (wait_q == 2'd2) begin
                    state_d  = S_DONE;
                    result_d = cap_val;
                    sat_d    = cap_sat;
                end
            end
            S_DONE: begin
                if (bus.RES_READY) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            load_q      <= 1'b1;
            sub_q       <= 1'b0;
            issue_vld_q <= 1'b0;
            op_vld_q    <= 1'b0;
            wait_q      <= '0;
            result_q    <= '0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            load_q      <= load_d;
            sub_q       <= sub_d;
            issue_vld_q <= issue_vld_d;
            op_vld_q    <= issue_vld_q;
            wait_q      <= wait_d;
            result_q    <= result_d;
            sat_q       <= sat_d;
        end
    end

    assign bus.BUSY      = (state_q != S_IDLE);
    assign bus.RES_VALID = (state_q == S_DONE);
    assign bus.RESULT    = result_q;
    assign bus.SAT       = sat_q;
    assign bus.OP_ADDR   = addr_q;
    assign bus.MAC_LOAD  = load_q;
    assign bus.MAC_SUB   = sub_q;
    assign bus.MAC_A     = op_vld_q ? bus.OPA_DATA : '0;
    assign bus.MAC_B     = op_vld_q ? bus.OPB_DATA : '0;
endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Bench for mac_dot_sequencer: operand memories, a 2-stage MAC, a transaction-level
// reference model with a per-cycle compare process, and directed commands.
module tb_mac_dot_sequencer;
    localparam int AW = 18;
    localparam int RW = 48;
    localparam int DW = 10;
    localparam int LW = 8;
    localparam int MEMN = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    mac_dot_sequencer_if #(.A_WIDTH(AW), .RES_WIDTH(RW), .ADDR_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

    mac_dot_sequencer #(
        .A_WIDTH(AW), .RES_WIDTH(RW), .ADDR_WIDTH(DW), .LEN_WIDTH(LW), .SAT_WIDTH(32)
    ) dut (
        .CLK(clk),
        .RST_N(rst_n),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- environment: memories and MAC ----------------
    logic signed [AW-1:0] memA [MEMN];
    logic signed [AW-1:0] memB [MEMN];
    logic [AW-1:0] rd_a = '0;
    logic [AW-1:0] rd_b = '0;
    always @(posedge clk) begin
        rd_a <= memA[bus.OP_ADDR];
        rd_b <= memB[bus.OP_ADDR];
    end
    assign bus.OPA_DATA = rd_a;
    assign bus.OPB_DATA = rd_b;

    function automatic logic signed [RW-1:0] sx(input logic [AW-1:0] v);
        return {{(RW-AW){v[AW-1]}}, v};
    endfunction

    logic [1:0]           mctl_q  = 2'b10;
    logic                 mload_q = 1'b1;
    logic                 msub_q  = 1'b0;
    logic signed [RW-1:0] mprod_q = '0;
    logic signed [RW-1:0] macc_q  = '0;
    always @(posedge clk) begin
        mctl_q  <= {bus.MAC_LOAD, bus.MAC_SUB};
        mprod_q <= sx(bus.MAC_A) * sx(bus.MAC_B);
        mload_q <= mctl_q[1];
        msub_q  <= mctl_q[0];
        macc_q  <= (mload_q ? macc_q : '0) + (msub_q ? -mprod_q : mprod_q);
    end
    assign bus.MAC_RES = macc_q;

    // ---------------- reference model (transaction level) ----------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit                   m_busy = 1'b0;
    int                   m_s = 0;
    int                   m_base = 0;
    int                   m_len = 0;
    bit                   m_sub = 1'b0;
    bit                   m_accf = 1'b0;
    logic signed [RW-1:0] m_acc = '0;
    logic [RW-1:0]        m_res = '0;
    bit                   m_sat = 1'b0;

    initial begin : model
        longint sum;
        longint r;
        int span;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_busy = 1'b0;
            end else if (m_busy) begin
                span = (m_len == 0) ? 1 : m_len;
                if (cyc >= m_s + span + 3 && bus.RES_READY) m_busy = 1'b0;
            end else if (bus.START) begin
                m_busy = 1'b1;
                m_s    = cyc + 1;
                m_base = int'(bus.CMD_BASE);
                m_len  = int'(bus.CMD_LEN);
                m_sub  = bus.CMD_SUB;
                m_accf = bus.CMD_ACC;
                sum = 0;
                for (int k = 0; k < m_len; k++)
                    sum += longint'(memA[(m_base + k) % MEMN]) * longint'(memB[(m_base + k) % MEMN]);
                r = (m_accf ? longint'(m_acc) : 64'sd0) + (m_sub ? -sum : sum);
                m_acc = r[RW-1:0];
                m_res = m_acc;
                m_sat = 1'b0;
`ifdef MAC_SEQ_SAT_EN
                if (longint'(m_acc) > 64'sh7FFFFFFF) begin
                    m_res = 48'h0000_7FFF_FFFF;
                    m_sat = 1'b1;
                end else if (longint'(m_acc) < -(64'sh80000000)) begin
                    m_res = 48'hFFFF_8000_0000;
                    m_sat = 1'b1;
                end
`endif
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int   c_c, c_span, c_idx;
    bit   c_issue, c_valid;
    logic [AW-1:0] c_ea, c_eb;
    initial begin : compare
        forever begin
            @(negedge clk);
            c_c     = cyc;
            c_span  = (m_len == 0) ? 1 : m_len;
            c_issue = m_busy && c_c >= m_s && c_c < m_s + c_span;
            c_valid = m_busy && c_c >= m_s + c_span + 3;
            chk("busy", 64'(bus.BUSY), 64'(m_busy));
            chk("res_valid", 64'(bus.RES_VALID), 64'(c_valid));
            chk("mac_load", 64'(bus.MAC_LOAD), 64'(c_issue ? (c_c == m_s ? m_accf : 1'b1) : 1'b1));
            chk("mac_sub", 64'(bus.MAC_SUB), 64'(c_issue ? m_sub : 1'b0));
            if (c_issue && m_len != 0)
                chk("op_addr", 64'(bus.OP_ADDR), 64'((m_base + c_c - m_s) % MEMN));
            c_ea = '0;
            c_eb = '0;
            if (m_busy && m_len != 0 && c_c >= m_s + 1 && c_c <= m_s + m_len) begin
                c_idx = (m_base + c_c - m_s - 1) % MEMN;
                c_ea  = memA[c_idx];
                c_eb  = memB[c_idx];
            end
            chk("mac_a", 64'(bus.MAC_A), 64'(c_ea));
            chk("mac_b", 64'(bus.MAC_B), 64'(c_eb));
            if (c_valid) begin
                chk("result", 64'(bus.RESULT), 64'(m_res));
                chk("sat", 64'(bus.SAT), 64'(m_sat));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    int addr_seen [4];

    task automatic run_cmd(input int base, input int len, input bit sub, input bit acc,
                           input int exp_lat, input logic [RW-1:0] exp_res, input bit exp_sat,
                           input int hold, input bit pulse);
        int lat;
        @(negedge clk);
        bus.START    = 1'b1;
        bus.CMD_BASE = DW'(base);
        bus.CMD_LEN  = LW'(len);
        bus.CMD_SUB  = sub;
        bus.CMD_ACC  = acc;
        @(negedge clk);
        bus.START = 1'b0;
        lat = 0;
        while (!bus.RES_VALID && lat < 600) begin
            if (lat < 4) addr_seen[lat] = int'(bus.OP_ADDR);
            @(negedge clk);
            lat++;
            if (pulse) begin
                bus.START    = lat[0];
                bus.CMD_BASE = 10'h155;
                bus.CMD_LEN  = 8'd3;
                bus.CMD_ACC  = 1'b1;
            end
        end
        bus.START = 1'b0;
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("lit_result", 64'(bus.RESULT), 64'(exp_res));
        chk("lit_sat", 64'(bus.SAT), 64'(exp_sat));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 64'(bus.RES_VALID), 64'd1);
            chk("hold_result", 64'(bus.RESULT), 64'(exp_res));
        end
        bus.RES_READY = 1'b1;
        @(negedge clk);
        bus.RES_READY = 1'b0;
        chk("idle_after_ready", 64'(bus.BUSY), 64'd0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        for (int i = 0; i < MEMN; i++) begin
            memA[i] = '0;
            memB[i] = '0;
        end
        for (int i = 0; i < 4; i++) begin
            memA[i] = 18'(i + 1);
            memB[i] = 18'(i + 5);
        end
        memA[1022] = 18'sd10;
        memB[1022] = 18'sd2;
        memA[1023] = -18'sd3;
        memB[1023] = 18'sd7;
        bus.START = 1'b0;
        bus.CMD_BASE = '0;
        bus.CMD_LEN = '0;
        bus.CMD_SUB = 1'b0;
        bus.CMD_ACC = 1'b0;
        bus.RES_READY = 1'b0;

        #1 rst_n = 1'b0;
        #3;
        chk("rst_busy", 64'(bus.BUSY), 64'd0);
        chk("rst_valid", 64'(bus.RES_VALID), 64'd0);
        chk("rst_result", 64'(bus.RESULT), 64'd0);
        chk("rst_sat", 64'(bus.SAT), 64'd0);
        chk("rst_addr", 64'(bus.OP_ADDR), 64'd0);
        chk("rst_load", 64'(bus.MAC_LOAD), 64'd1);
        chk("rst_sub", 64'(bus.MAC_SUB), 64'd0);
        chk("rst_mac_a", 64'(bus.MAC_A), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_cmd(0, 4, 1'b0, 1'b0, 7, 48'd70, 1'b0, 0, 1'b0);
        for (int i = 0; i < 4; i++) chk("addr_seq0", 64'(addr_seen[i]), 64'(i));
        run_cmd(0, 4, 1'b1, 1'b1, 7, 48'd0, 1'b0, 0, 1'b0);
        run_cmd(0, 4, 1'b1, 1'b0, 7, 48'hFFFF_FFFF_FFBA, 1'b0, 0, 1'b0);
        run_cmd(0, 0, 1'b0, 1'b0, 4, 48'd0, 1'b0, 0, 1'b0);
        run_cmd(0, 4, 1'b0, 1'b0, 7, 48'd70, 1'b0, 0, 1'b0);
        run_cmd(0, 0, 1'b0, 1'b1, 4, 48'd70, 1'b0, 0, 1'b0);

        run_cmd(1022, 4, 1'b0, 1'b0, 7, 48'd16, 1'b0, 5, 1'b1);
        chk("addr_wrap0", 64'(addr_seen[0]), 64'd1022);
        chk("addr_wrap1", 64'(addr_seen[1]), 64'd1023);
        chk("addr_wrap2", 64'(addr_seen[2]), 64'd0);
        chk("addr_wrap3", 64'(addr_seen[3]), 64'd1);

        for (int i = 0; i < 255; i++) begin
            memA[i] = -18'sd131072;
            memB[i] = -18'sd131072;
        end
`ifdef MAC_SEQ_SAT_EN
        run_cmd(0, 255, 1'b0, 1'b0, 258, 48'h0000_7FFF_FFFF, 1'b1, 0, 1'b0);
`else
        run_cmd(0, 255, 1'b0, 1'b0, 258, 48'h03FC_0000_0000, 1'b0, 0, 1'b0);
`endif

        for (int i = 0; i < 4; i++) begin
            memA[i] = 18'(i + 1);
            memB[i] = 18'(i + 5);
        end
        @(negedge clk);
        bus.START    = 1'b1;
        bus.CMD_BASE = '0;
        bus.CMD_LEN  = 8'd8;
        bus.CMD_SUB  = 1'b0;
        bus.CMD_ACC  = 1'b0;
        @(negedge clk);
        bus.START = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(bus.BUSY), 64'd0);
        chk("midrst_valid", 64'(bus.RES_VALID), 64'd0);
        chk("midrst_mac_a", 64'(bus.MAC_A), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_cmd(0, 4, 1'b0, 1'b0, 7, 48'd70, 1'b0, 0, 1'b0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mac_dot_sequencer.md
Name: mac_dot_sequencer

Overview:
- Sequences one pipelined signed multiply-accumulate (MAC) unit to compute dot products of length N, for example R = ±sum(A[i]*B[i]) or R = R ± sum(A[i]*B[i]).
- Reads operand pairs from two synchronous operand memories that share one address bus.
- Drives the MAC's A/B operands and its load/add-sub controls with the MAC's required control lead.
- Captures the final accumulator and returns it over a valid/ready handshake.

Parameters:
- A_WIDTH, 18, signed operand width of A and B.
- RES_WIDTH, 48, MAC accumulator/result width.
- ADDR_WIDTH, 10, operand memory address width.
- LEN_WIDTH, 8, width of term count CMD_LEN.
- SAT_WIDTH, 32, saturation width; used only with MAC_SEQ_SAT_EN.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  command strobe; accepted only in IDLE.
- CMD_BASE  in  ADDR_WIDTH  first operand address.
- CMD_LEN  in  LEN_WIDTH  number of terms N.
- CMD_SUB  in  1  1: subtract every product; 0: add.
- CMD_ACC  in  1  1: continue from the current accumulator; 0: start from zero.
- BUSY  out  1  high whenever state is not IDLE.
- OP_ADDR  out  ADDR_WIDTH  operand memory address; memory read latency is 1.
- OPA_DATA, OPB_DATA  in  A_WIDTH each  operand memory read data.
- MAC_A, MAC_B  out  A_WIDTH each  MAC operands.
- MAC_LOAD, MAC_SUB  out  1 each  MAC controls. LOAD=0 gives R=±A*B; LOAD=1 gives R=R±A*B.
- MAC_RES  in  RES_WIDTH  MAC result.
- RES_VALID  out  1  result available.
- RES_READY  in  1  result consumed.
- RESULT  out  RES_WIDTH  captured result.
- SAT  out  1  saturation occurred.

Behaviour:
- MAC timing contract:
  - Controls must be presented 1 cycle before their operands.
  - Operands on MAC_A/MAC_B in cycle t are reflected on MAC_RES in cycle t+2.
- States: IDLE, ISSUE, WAIT, DONE.
- Reset values (asynchronous, on RST_N=0):
  - State = IDLE.
  - BUSY=0, RES_VALID=0, RESULT=0, SAT=0.
  - OP_ADDR=0, MAC_LOAD=1, MAC_SUB=0.
  - Operand-valid flag = 0, so MAC_A=MAC_B=0.
  - The MAC datapath itself is not reset. The first command after reset must use CMD_ACC=0; otherwise the result is undefined.
- IDLE:
  - MAC_LOAD=1, MAC_SUB=0, operands forced to 0, so the MAC holds its value.
  - START=1 latches CMD_* and moves to ISSUE in cycle s.
  - START while BUSY is ignored.
- ISSUE, term k = 0..N-1, in cycle s+k:
  - OP_ADDR = CMD_BASE+k, wrapping modulo 2^ADDR_WIDTH.
  - MAC_LOAD = CMD_ACC for k=0, and 1 for k>0.
  - MAC_SUB = CMD_SUB.
- Operand path:
  - In cycle s+k+1, MAC_A=OPA_DATA and MAC_B=OPB_DATA, gated by a 1-cycle-delayed operand-valid flag.
  - Outside valid cycles, MAC_A and MAC_B are 0.
- After the last issue, MAC_LOAD=1 and MAC_SUB=0 (hold). State goes to WAIT.
- WAIT: count cycles. In cycle s+N+2, MAC_RES is final; latch it into RESULT at the end of that cycle.
- DONE:
  - RES_VALID=1 from cycle s+N+3, held with RESULT stable until RES_READY=1.
  - On the cycle RES_READY=1, the handshake completes and state returns to IDLE. BUSY drops the next cycle.
- Total latency from START to RES_VALID: N+3 cycles.
- Boundary N=0:
  - Treated as one zero-operand term: LOAD=CMD_ACC, operands forced 0, no valid address phase.
  - Result is 0 (CMD_ACC=0) or the held accumulator (CMD_ACC=1). Latency is 4.
- Boundary N=2^LEN_WIDTH-1: the term counter must not overflow.
- Accumulator overflow: RES_WIDTH arithmetic wraps two's-complement, matching the MAC. No detection.
- Reset mid-command: immediate return to IDLE. The accumulator contents are undefined afterwards.

Optional Feature:
- Macro: MAC_SEQ_SAT_EN.
- With the macro:
  - On capture, a MAC_RES outside the signed SAT_WIDTH range is clamped to 2^(SAT_WIDTH-1)-1 or -2^(SAT_WIDTH-1), sign-extended to RES_WIDTH.
  - SAT=1 is registered alongside RESULT.
  - Values in range pass unchanged with SAT=0.
- Without the macro: RESULT=MAC_RES, and SAT is tied 0.

Test Plan:
- Reset, memory A[0..3]={1,2,3,4}, B[0..3]={5,6,7,8}; START with BASE=0, LEN=4, SUB=0, ACC=0 → RES_VALID in cycle s+7, RESULT=70, OP_ADDR sequence 0,1,2,3.
- Repeat with ACC=1, SUB=1 → RESULT=0. Then ACC=0, SUB=1 → RESULT=-70 (0xFFFFFFFFFFBA).
- LEN=0, ACC=0 → RESULT=0 after 4 cycles. LEN=0, ACC=1 after a result of 70 → RESULT=70.
- BASE=1022, LEN=4, ADDR_WIDTH=10 → OP_ADDR = 1022, 1023, 0, 1. START pulses during BUSY are ignored. RES_READY held low for 5 cycles → RESULT stable, then IDLE.
- Operands A=B=-131072 over LEN=255 with MAC_SEQ_SAT_EN, SAT_WIDTH=32 → RESULT=0x7FFFFFFF, SAT=1. Without the macro → RESULT = 255*2^34 exact, SAT=0.
- RST_N asserted during ISSUE at k=2 → BUSY=0 and RES_VALID=0 immediately. A subsequent ACC=0 command produces a correct result.
